// File: rtl/debug_ring_ext_link.sv
// Bridges two debug-ring channels onto one multiplexed link: packet-locked
// arbitration into a one-flit output register, and per-channel receive FIFOs.
package debug_ring_ext_link_pkg;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

module debug_ring_ext_link
    import debug_ring_ext_link_pkg::*;
#(
    parameter int unsigned BUFFER_SIZE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  dii_flit [1:0] ext_out,
    output logic    [1:0] ext_out_ready,
    output dii_flit [1:0] ext_in,
    input  logic    [1:0] ext_in_ready,
    output dii_flit       link_out,
    output logic          link_out_chan,
    input  logic          link_out_ready,
    input  dii_flit       link_in,
    input  logic          link_in_chan,
    output logic          link_in_ready
);

    localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t     r_state;
    logic       r_last_grant;
    dii_flit    r_out;
    logic       r_out_chan;

    logic       w_can_accept;
    logic [1:0] w_grantable;
    logic [1:0] w_ext_ready;
    logic       w_gnt;
    logic       w_xfer;

    // Grantable channels: locked channel only, else round-robin on contention
    always_comb begin
        w_grantable = 2'b00;
        case (r_state)
            IDLE: begin
                w_grantable[0] = ext_out[0].valid && (!ext_out[1].valid || r_last_grant);
                w_grantable[1] = ext_out[1].valid && (!ext_out[0].valid || !r_last_grant);
            end
            LOCK0:   w_grantable = 2'b01;
            LOCK1:   w_grantable = 2'b10;
            default: w_grantable = 2'b00;
        endcase
        w_can_accept = !r_out.valid || link_out_ready;
        w_ext_ready  = (rst && w_can_accept) ? w_grantable : 2'b00;
        w_gnt        = w_ext_ready[1];
        w_xfer       = |(w_ext_ready & {ext_out[1].valid, ext_out[0].valid});
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_out        <= '0;
            r_out_chan   <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_out      <= ext_out[w_gnt];
                r_out_chan <= w_gnt;
                if (ext_out[w_gnt].last) begin
                    r_state      <= IDLE;
                    r_last_grant <= w_gnt;
                end else begin
                    r_state <= w_gnt ? LOCK1 : LOCK0;
                end
            end else if (link_out_ready) begin
                r_out.valid <= 1'b0;
            end
        end
    end

    assign ext_out_ready = w_ext_ready;
    assign link_out      = r_out;
    assign link_out_chan = r_out_chan;

    logic [16:0]      r_mem [2][BUFFER_SIZE];
    logic [PTR_W-1:0] r_wr  [2];
    logic [PTR_W-1:0] r_rd  [2];
    logic [CNT_W-1:0] r_cnt [2];

    logic [1:0] w_push;
    logic [1:0] w_pop;
    logic [1:0] w_full;
    logic       w_link_in_ready;

    // A full FIFO still accepts when its head is leaving the same cycle
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_full[n] = (r_cnt[n] == CNT_W'(BUFFER_SIZE));
            w_pop[n]  = rst && ext_in_ready[n] && (r_cnt[n] != '0);
        end
        w_link_in_ready = rst && (!w_full[link_in_chan] || w_pop[link_in_chan]);
        for (int n = 0; n < 2; n++) begin
            w_push[n]        = link_in.valid && w_link_in_ready && (link_in_chan == 1'(n));
            ext_in[n].valid  = rst && (r_cnt[n] != '0);
            ext_in[n].last   = r_mem[n][r_rd[n]][16];
            ext_in[n].data   = r_mem[n][r_rd[n]][15:0];
        end
    end

    assign link_in_ready = w_link_in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int n = 0; n < 2; n++) begin
                r_wr[n]  <= '0;
                r_rd[n]  <= '0;
                r_cnt[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_push[n]) r_wr[n] <= r_wr[n] + PTR_W'(1);
                if (w_pop[n])  r_rd[n] <= r_rd[n] + PTR_W'(1);
                r_cnt[n] <= r_cnt[n] + CNT_W'(w_push[n]) - CNT_W'(w_pop[n]);
            end
        end
    end

    // Storage needs no reset; validity comes from the counters
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (w_push[n]) r_mem[n][r_wr[n]] <= {link_in.last, link_in.data};
        end
    end

endmodule

// File: tb/tb_debug_ring_ext_link.sv
// Directed bench for debug_ring_ext_link: arbitration, stall, FIFO limits, reset.
module tb_debug_ring_ext_link;
    import debug_ring_ext_link_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    dii_flit [1:0] ext_out;
    logic    [1:0] ext_out_ready;
    dii_flit [1:0] ext_in;
    logic    [1:0] ext_in_ready;
    dii_flit       link_out;
    logic          link_out_chan;
    logic          link_out_ready;
    dii_flit       link_in;
    logic          link_in_chan;
    logic          link_in_ready;

    int total = 0;
    int bad   = 0;

    debug_ring_ext_link #(.BUFFER_SIZE(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ext_out        (ext_out),
        .ext_out_ready  (ext_out_ready),
        .ext_in         (ext_in),
        .ext_in_ready   (ext_in_ready),
        .link_out       (link_out),
        .link_out_chan  (link_out_chan),
        .link_out_ready (link_out_ready),
        .link_in        (link_in),
        .link_in_chan   (link_in_chan),
        .link_in_ready  (link_in_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; checks happen at the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    function automatic dii_flit fl(input logic last, input logic [15:0] d);
        fl = '{valid: 1'b1, last: last, data: d};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b0;
        ext_out        = '0;
        ext_in_ready   = 2'b00;
        link_out_ready = 1'b1;
        link_in        = '0;
        link_in_chan   = 1'b0;

        // Reset: ready gated low even with traffic offered
        tick();
        ext_out[0] = fl(1'b0, 16'h5555);
        link_in    = fl(1'b0, 16'h6666);
        settle();
        check("rst_ext_out_ready", 32'(ext_out_ready), 32'h0);
        check("rst_link_in_ready", 32'(link_in_ready), 32'h0);
        check("rst_link_out_valid", 32'(link_out.valid), 32'h0);
        check("rst_ext_in_valid", 32'({ext_in[1].valid, ext_in[0].valid}), 32'h0);
        tick();
        ext_out = '0;
        link_in = '0;
        rst     = 1'b1;

        // Three-flit packet on channel 0
        ext_out[0] = fl(1'b0, 16'h1111);
        settle();
        check("p1_ready0", 32'(ext_out_ready), 32'h1);
        check("p1_link_in_ready", 32'(link_in_ready), 32'h1);
        tick();
        ext_out[0] = fl(1'b0, 16'h2222);
        settle();
        check("p1_f1", 32'(link_out), 32'h2_1111);
        check("p1_f1_chan", 32'(link_out_chan), 32'h0);
        tick();
        ext_out[0] = fl(1'b1, 16'h3333);
        settle();
        check("p1_f2", 32'(link_out), 32'h2_2222);
        tick();
        ext_out[0] = '0;
        settle();
        check("p1_f3", 32'(link_out), 32'h3_3333);
        check("p1_f3_chan", 32'(link_out_chan), 32'h0);
        tick();
        settle();
        check("p1_idle", 32'(link_out.valid), 32'h0);

        // Contention after reset: channel 0 first, no interleaving
        do_reset();
        ext_out[0] = fl(1'b0, 16'hA0A0);
        ext_out[1] = fl(1'b0, 16'hB0B0);
        settle();
        check("arb_ready_a", 32'(ext_out_ready), 32'h1);
        tick();
        ext_out[0] = fl(1'b1, 16'hA1A1);
        settle();
        check("arb_f0", 32'(link_out), 32'h2_A0A0);
        check("arb_lock_ready", 32'(ext_out_ready), 32'h1);
        tick();
        ext_out[0] = '0;
        settle();
        check("arb_f1", 32'({link_out_chan, link_out}), 32'h3_A1A1);
        check("arb_ready_b", 32'(ext_out_ready), 32'h2);
        tick();
        ext_out[1] = fl(1'b1, 16'hB1B1);
        settle();
        check("arb_f2", 32'({link_out_chan, link_out}), 32'h6_B0B0);
        check("arb_lock1_ready", 32'(ext_out_ready), 32'h2);
        tick();
        ext_out[1] = '0;
        settle();
        check("arb_f3", 32'({link_out_chan, link_out}), 32'h7_B1B1);
        tick();

        // Output stall mid-packet
        ext_out[0] = fl(1'b0, 16'hC0C0);
        tick();
        ext_out[0] = fl(1'b0, 16'hC1C1);
        tick();
        ext_out[0]     = fl(1'b1, 16'hC2C2);
        link_out_ready = 1'b0;
        settle();
        check("stall_hold0", 32'(link_out), 32'h2_C1C1);
        check("stall_ready0", 32'(ext_out_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            check($sformatf("stall_hold%0d", i + 1), 32'({ext_out_ready, link_out}), 32'h2_C1C1);
        end
        tick();
        link_out_ready = 1'b1;
        settle();
        check("stall_release_ready", 32'(ext_out_ready), 32'h1);
        tick();
        ext_out[0] = '0;
        settle();
        check("stall_last", 32'(link_out), 32'h3_C2C2);
        tick();
        settle();
        check("stall_drained", 32'(link_out.valid), 32'h0);

        // FIFO 0 fills to four, fifth back-pressured, channel 1 unaffected
        do_reset();
        for (int i = 0; i < 5; i++) begin
            link_in      = fl(1'b0, 16'hD000 + 16'(i));
            link_in_chan = 1'b0;
            settle();
            check($sformatf("fill0_ready%0d", i), 32'(link_in_ready), (i < 4) ? 32'h1 : 32'h0);
            tick();
        end
        link_in      = fl(1'b1, 16'hE000);
        link_in_chan = 1'b1;
        settle();
        check("fill0_head", 32'(ext_in[0]), 32'h2_D000);
        check("ch1_ready", 32'(link_in_ready), 32'h1);
        tick();
        link_in      = '0;
        ext_in_ready = 2'b11;
        settle();
        check("ch1_head", 32'(ext_in[1]), 32'h3_E000);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) settle();
            check($sformatf("drain0_%0d", i), 32'(ext_in[0]), 32'h2_D000 + 32'(i));
            tick();
        end
        settle();
        check("drain0_empty", 32'({ext_in[1].valid, ext_in[0].valid}), 32'h0);

        // FIFO 1 full with simultaneous push and pop
        ext_in_ready = 2'b00;
        link_in_chan = 1'b1;
        for (int i = 0; i < 4; i++) begin
            link_in = fl(1'(i == 3), 16'hF000 + 16'(i));
            tick();
        end
        link_in      = fl(1'b1, 16'hF004);
        ext_in_ready = 2'b10;
        settle();
        check("full_pushpop_ready", 32'(link_in_ready), 32'h1);
        check("full_head", 32'(ext_in[1]), 32'h2_F000);
        tick();
        link_in      = fl(1'b0, 16'hF005);
        ext_in_ready = 2'b00;
        settle();
        check("full_still", 32'(link_in_ready), 32'h0);
        tick();
        link_in      = '0;
        ext_in_ready = 2'b10;
        for (int i = 1; i < 5; i++) begin
            settle();
            check($sformatf("drain1_%0d", i), 32'(ext_in[1]),
                  {14'h0, 1'b1, 1'(i >= 3), 16'hF000 + 16'(i)});
            tick();
        end
        settle();
        check("drain1_empty", 32'(ext_in[1].valid), 32'h0);
        ext_in_ready = 2'b00;

        // Reset in the middle of a packet with buffered inbound data
        ext_out[0]   = fl(1'b0, 16'h7777);
        link_in      = fl(1'b1, 16'h9999);
        link_in_chan = 1'b0;
        tick();
        link_in    = '0;
        ext_out[0] = fl(1'b0, 16'h8888);
        rst        = 1'b0;
        settle();
        check("mid_rst_ready", 32'({link_in_ready, ext_out_ready}), 32'h0);
        check("mid_rst_ext_in", 32'({ext_in[1].valid, ext_in[0].valid}), 32'h0);
        tick();
        rst        = 1'b1;
        ext_out[0] = '0;
        ext_out[1] = fl(1'b1, 16'hABCD);
        settle();
        check("post_rst_link_out", 32'(link_out.valid), 32'h0);
        check("post_rst_ext_in", 32'({ext_in[1].valid, ext_in[0].valid}), 32'h0);
        check("post_rst_link_in_ready", 32'(link_in_ready), 32'h1);
        check("post_rst_ext_out_ready", 32'(ext_out_ready), 32'h2);
        tick();
        ext_out[1] = '0;
        settle();
        check("post_rst_flit", 32'({link_out_chan, link_out}), 32'h7_ABCD);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_ring_ext_link.md
DEBUG_RING_EXT_LINK -- requirements
Module: debug_ring_ext_link

Interface
REQ-001 The block SHALL have parameter BUFFER_SIZE, default 4, giving the per-channel receive FIFO depth (power of two, >=2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; it is synchronous and active-low.
REQ-004 The block SHALL have port ext_out, input, dii_flit[1:0], ring channel 0/1 flits leaving an expanded ring segment.
REQ-005 The block SHALL have port ext_out_ready, output, [1:0], the per-channel ready back to the ring.
REQ-006 The block SHALL have port ext_in, output, dii_flit[1:0], ring channel 0/1 flits entering the ring segment.
REQ-007 The block SHALL have port ext_in_ready, input, [1:0], the per-channel ready from the ring.
REQ-008 The block SHALL have port link_out, output, dii_flit, the single multiplexed outbound link flit (valid, last, data[15:0]).
REQ-009 The block SHALL have port link_out_chan, output, 1, the ring channel tag of link_out.
REQ-010 The block SHALL have port link_out_ready, input, 1, the outbound link accept.
REQ-011 The block SHALL have port link_in, input, dii_flit, the multiplexed inbound link flit.
REQ-012 The block SHALL have port link_in_chan, input, 1, the channel tag of link_in.
REQ-013 The block SHALL have port link_out_ready's counterpart link_in_ready, output, 1, the inbound link accept.

Function
REQ-014 A flit SHALL transfer on any interface only in a cycle where valid=1 and ready=1 at the same clock edge.
REQ-015 The mux path SHALL hold a one-flit output register for link_out, link_out_chan; link_out.valid SHALL be driven only from this register.
REQ-016 The mux path SHALL accept a flit when the register is empty or is being drained in the same cycle (link_out_ready=1); the latency from ext_out acceptance to link_out valid SHALL be 1 cycle.
REQ-017 Arbitration SHALL be packet-locked: the state machine SHALL have states IDLE, LOCK0 and LOCK1.
REQ-018 In IDLE with one channel valid, that channel SHALL be granted; with both channels valid, the channel opposite to last_grant SHALL be granted.
REQ-019 A granted flit with last=0 SHALL move the FSM to LOCKn; an accepted flit with last=1 SHALL return it to IDLE and set last_grant=n.
REQ-020 In LOCKn, only channel n SHALL be granted; the other channel's ext_out_ready SHALL be 0.
REQ-021 ext_out_ready[n] SHALL be 1 only if channel n is grantable this cycle and the output register can accept.
REQ-022 A single-flit packet (last=1) SHALL grant and release in the same cycle without entering LOCK.
REQ-023 The demux path SHALL hold one FIFO per channel of depth BUFFER_SIZE; an inbound flit SHALL be written to FIFO[link_in_chan].
REQ-024 link_in_ready SHALL be 1 when FIFO[link_in_chan] is not full, or when it is full and being popped in the same cycle.
REQ-025 ext_in[n].valid SHALL be 1 when FIFO[n] is non-empty; the FIFO head flit (last, data) SHALL be presented unchanged; a pop SHALL occur on ext_in_ready[n].
REQ-026 A simultaneous push and pop on the same FIFO SHALL keep the count unchanged, including at full and at empty (fall-through not required; empty+push gives valid next cycle).
REQ-027 FIFO pointers SHALL wrap modulo BUFFER_SIZE; the count SHALL be log2(BUFFER_SIZE)+1 bits wide.
REQ-028 A full FIFO on one channel SHALL back-pressure the link only for flits tagged with that channel.
REQ-029 Flit contents (last, data) SHALL never be altered, dropped or reordered within a channel.

Reset
REQ-030 While rst=0 at a clock edge: FSM=IDLE, last_grant=1, output register empty, FIFOs empty; all valid outputs SHALL be 0, and ext_out_ready, link_in_ready SHALL be 0 during reset.
REQ-031 A reset mid-packet SHALL discard the partial packet and all buffered flits; the first cycle after rst=1 SHALL show link_in_ready=1, and ext_out_ready follows REQ-021.

Verification
REQ-032 Channel 0 sends a 3-flit packet 0x1111/0x2222/0x3333(last) with link_out_ready=1 -> link_out shows the flits on cycles +1..+3 with chan=0 and last on the third flit.
REQ-033 Both channels present 2-flit packets simultaneously after reset -> channel 0 is sent first (last_grant=1), ext_out_ready[1]=0 until channel 0's last flit is accepted, then channel 1 is sent; there is no interleaving.
REQ-034 With link_out_ready=0 for 5 cycles mid-packet -> link_out holds the flit stable and no ext_out flit is lost or duplicated.
REQ-035 BUFFER_SIZE=4 with ext_in_ready[0]=0 and 5 channel-0 flits inbound -> 4 are accepted, link_in_ready=0 on the fifth, and a channel-1 flit presented next is accepted.
REQ-036 FIFO[1] is full and ext_in_ready[1]=1 while a channel-1 flit is inbound -> push and pop occur in the same cycle and the count stays 4.
REQ-037 rst=0 asserted during the second flit of a packet -> all valids are 0 the next cycle and the FSM is in IDLE; a new packet after release is sent cleanly.
